seg_scan: RTL and testbench

SEG_SCAN -- requirements
Module: seg_scan

---
 rtl/seg_pkg.sv | 34 +++
 rtl/seg_hex_decode.sv | 18 +
 rtl/seg_scan.sv | 155 +++++++++++++++
 tb/tb_seg_scan.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed seven-segment scanner.
// Segment byte is active-low {dp,g,f,e,d,c,b,a}.
package seg_pkg;

    typedef enum logic {
        StBlank = 1'b0,
        StShow  = 1'b1
    } state_e;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [3:0] SD_OFF  = 4'hF;

    // Entry n is the dp-off pattern for hex value n.
    localparam logic [15:0][7:0] HEX_SEG = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    // Bit n set when digit n is a blankable leading zero; digit 0 is never blanked.
    function automatic logic [3:0] lz_blank(input logic [15:0] data,
                                            input logic [3:0]  dp,
                                            input logic        lz);
        logic [3:0] blank;
        logic       run;
        blank = 4'b0000;
        run   = lz;
        for (int n = 3; n >= 1; n--) begin
            run      = run && (data[4*n +: 4] == 4'h0) && !dp[n];
            blank[n] = run;
        end
        return blank;
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex-to-segment decoder with decimal point and blanking.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       dp_i,
    input  logic       blank_i,
    output logic [7:0] seg_o
);

    always_comb begin
        seg_o = SEG_OFF;
        if (!blank_i) begin
            seg_o = HEX_SEG[nibble_i] & ~{dp_i, 7'b000_0000};
        end
    end

endmodule

// File: rtl/seg_scan.sv
// Four-digit multiplexed display scanner with blank/show timing and a
// one-word pending buffer committed only at frame boundaries.
module seg_scan
    import seg_pkg::*;
#(
    parameter int unsigned DIV  = 50000,
    parameter int unsigned DEAD = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    input  logic [3:0]  in_dp,
    input  logic        in_lz,
    output logic        in_ready,
    output logic [3:0]  SD,
    output logic [7:0]  SEG,
    output logic        frame_done
);

    localparam int unsigned CntMax = (DIV > DEAD) ? DIV : DEAD;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
    localparam logic [CntW-1:0] DivLast  = CntW'(DIV - 1);
    localparam logic [CntW-1:0] DeadLast = CntW'(DEAD - 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [15:0]     disp_data_q, disp_data_d;
    logic [3:0]      disp_dp_q, disp_dp_d;
    logic            disp_lz_q, disp_lz_d;
    logic [15:0]     buf_data_q, buf_data_d;
    logic [3:0]      buf_dp_q, buf_dp_d;
    logic            buf_lz_q, buf_lz_d;
    logic            pend_q, pend_d;
    logic [3:0]      sd_q, sd_d;
    logic [7:0]      seg_q, seg_d;
    logic            frame_done_q;

    logic            boundary;
    logic            accept;
    logic            commit;
    logic [3:0]      blank_vec;
    logic [3:0]      dec_nibble;
    logic            dec_dp;
    logic            dec_blank;
    logic [7:0]      dec_seg;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CntW'(1);
        idx_d    = idx_q;
        boundary = 1'b0;
        case (state_q)
            StBlank: begin
                if (cnt_q == DeadLast) begin
                    state_d = StShow;
                    cnt_d   = '0;
                end
            end
            StShow: begin
                if (cnt_q == DivLast) begin
                    state_d  = StBlank;
                    cnt_d    = '0;
                    idx_d    = idx_q + 2'd1;
                    boundary = (idx_q == 2'd3);
                end
            end
            default: begin
                state_d = StBlank;
                cnt_d   = '0;
            end
        endcase
    end

    // A word accepted on the boundary edge itself waits for the next boundary.
    always_comb begin
        accept      = in_valid && !pend_q;
        commit      = boundary && pend_q;
        disp_data_d = commit ? buf_data_q : disp_data_q;
        disp_dp_d   = commit ? buf_dp_q   : disp_dp_q;
        disp_lz_d   = commit ? buf_lz_q   : disp_lz_q;
        buf_data_d  = accept ? in_data    : buf_data_q;
        buf_dp_d    = accept ? in_dp      : buf_dp_q;
        buf_lz_d    = accept ? in_lz      : buf_lz_q;
        pend_d      = pend_q;
        if (commit) begin
            pend_d = 1'b0;
        end else if (accept) begin
            pend_d = 1'b1;
        end
    end

    // Outputs are decoded from next-state values so they move on the same edge.
    always_comb begin
        blank_vec  = lz_blank(disp_data_d, disp_dp_d, disp_lz_d);
        dec_nibble = disp_data_d[{idx_d, 2'b00} +: 4];
        dec_dp     = disp_dp_d[idx_d];
        dec_blank  = blank_vec[idx_d];
    end

    seg_hex_decode u_dec (
        .nibble_i (dec_nibble),
        .dp_i     (dec_dp),
        .blank_i  (dec_blank),
        .seg_o    (dec_seg)
    );

    always_comb begin
        sd_d  = SD_OFF;
        seg_d = SEG_OFF;
        if (state_d == StShow) begin
            sd_d  = ~(4'b0001 << idx_d);
            seg_d = dec_seg;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= StBlank;
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            disp_data_q  <= 16'h0000;
            disp_dp_q    <= 4'h0;
            disp_lz_q    <= 1'b0;
            buf_data_q   <= 16'h0000;
            buf_dp_q     <= 4'h0;
            buf_lz_q     <= 1'b0;
            pend_q       <= 1'b0;
            sd_q         <= SD_OFF;
            seg_q        <= SEG_OFF;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            disp_data_q  <= disp_data_d;
            disp_dp_q    <= disp_dp_d;
            disp_lz_q    <= disp_lz_d;
            buf_data_q   <= buf_data_d;
            buf_dp_q     <= buf_dp_d;
            buf_lz_q     <= buf_lz_d;
            pend_q       <= pend_d;
            sd_q         <= sd_d;
            seg_q        <= seg_d;
            frame_done_q <= boundary;
        end
    end

    assign in_ready   = ~pend_q;
    assign SD         = sd_q;
    assign SEG        = seg_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan with DIV=4, DEAD=1 (5-cycle digit, 20-cycle frame).
module tb_seg_scan;

    localparam int unsigned DIV  = 4;
    localparam int unsigned DEAD = 1;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = 16'h0000;
    logic [3:0]  in_dp = 4'h0;
    logic        in_lz = 1'b0;
    logic        in_ready;
    logic [3:0]  SD;
    logic [7:0]  SEG;
    logic        frame_done;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] cap_seg [4];
    bit         cap_got;
    bit         cap_sd_ok;
    bit         cap_pulse_ok;

    seg_scan #(
        .DIV  (DIV),
        .DEAD (DEAD)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_dp      (in_dp),
        .in_lz      (in_lz),
        .in_ready   (in_ready),
        .SD         (SD),
        .SEG        (SEG),
        .frame_done (frame_done)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Records one frame; starts at a negedge where frame_done is high.
    task automatic capture_frame(input bit already);
        int n;
        logic [3:0] one;
        cap_got      = 1'b1;
        cap_sd_ok    = 1'b1;
        cap_pulse_ok = 1'b1;
        if (!already) begin
            n = 0;
            @(negedge CLK);
            while (frame_done !== 1'b1 && n < 100) begin
                @(negedge CLK);
                n++;
            end
        end
        if (frame_done !== 1'b1) begin
            cap_got = 1'b0;
            for (int d = 0; d < 4; d++) cap_seg[d] = 8'hxx;
            return;
        end
        for (int d = 0; d < 4; d++) begin
            if (d != 0) begin
                @(negedge CLK);
                if (frame_done !== 1'b0) cap_pulse_ok = 1'b0;
            end
            if (SD !== 4'hF || SEG !== 8'hFF) cap_sd_ok = 1'b0;
            one = 4'b0001 << d;
            for (int k = 0; k < 4; k++) begin
                @(negedge CLK);
                if (frame_done !== 1'b0) cap_pulse_ok = 1'b0;
                if (SD !== ~one) cap_sd_ok = 1'b0;
                if (k == 0) cap_seg[d] = SEG;
                else if (SEG !== cap_seg[d]) cap_sd_ok = 1'b0;
            end
        end
    endtask

    task automatic load_word(input logic [15:0] data, input logic [3:0] dp, input logic lz);
        repeat (2) @(negedge CLK);
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL load_ready: in_ready=%b expected 1", in_ready);
        end
        in_valid = 1'b1;
        in_data  = data;
        in_dp    = dp;
        in_lz    = lz;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        in_data  = 16'hBEEF;
        in_dp    = 4'hF;
        in_lz    = 1'b1;
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_pend: in_ready=%b expected 0", in_ready);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge CLK);
        tests_run++;
        if (SD !== 4'hF || SEG !== 8'hFF || frame_done !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_state: SD=%h SEG=%h fd=%b rdy=%b expected F FF 0 1",
                     SD, SEG, frame_done, in_ready);
        end
        @(posedge CLK);
        #1;
        RST = 1'b1;
        @(negedge CLK);
        tests_run++;
        if (SD !== 4'hF || SEG !== 8'hFF) begin
            tests_failed++;
            $display("FAIL reset_first_blank: SD=%h SEG=%h expected F FF", SD, SEG);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            tests_run++;
            if (SD !== 4'b1110 || SEG !== 8'hC0) begin
                tests_failed++;
                $display("FAIL reset_first_show%0d: SD=%b SEG=%h expected 1110 C0", k, SD, SEG);
            end
        end
        @(negedge CLK);
        tests_run++;
        if (SD !== 4'hF || SEG !== 8'hFF) begin
            tests_failed++;
            $display("FAIL reset_second_blank: SD=%h SEG=%h expected F FF", SD, SEG);
        end
    endtask

    task automatic test_load_basic;
        logic [7:0] exp [4];
        load_word(16'h12AF, 4'h0, 1'b0);
        capture_frame(1'b0);
        exp = '{8'h8E, 8'h88, 8'hA4, 8'hF9};
        for (int d = 0; d < 4; d++) begin
            tests_run++;
            if (!cap_got || cap_seg[d] !== exp[d]) begin
                tests_failed++;
                $display("FAIL basic_digit%0d: SEG=%h expected %h", d, cap_seg[d], exp[d]);
            end
        end
        tests_run++;
        if (!(cap_got && cap_sd_ok && cap_pulse_ok)) begin
            tests_failed++;
            $display("FAIL basic_shape: got=%b sd_ok=%b pulse_ok=%b expected 1 1 1",
                     cap_got, cap_sd_ok, cap_pulse_ok);
        end
        @(negedge CLK);
        tests_run++;
        if (frame_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_period: frame_done=%b expected 1 after 20 cycles", frame_done);
        end
    endtask

    task automatic test_leading_zero;
        logic [7:0] exp [4];
        load_word(16'h0005, 4'h0, 1'b1);
        capture_frame(1'b0);
        exp = '{8'h92, 8'hFF, 8'hFF, 8'hFF};
        for (int d = 0; d < 4; d++) begin
            tests_run++;
            if (!cap_got || cap_seg[d] !== exp[d]) begin
                tests_failed++;
                $display("FAIL lz_0005_digit%0d: SEG=%h expected %h", d, cap_seg[d], exp[d]);
            end
        end
        load_word(16'h0000, 4'h0, 1'b1);
        capture_frame(1'b0);
        exp = '{8'hC0, 8'hFF, 8'hFF, 8'hFF};
        for (int d = 0; d < 4; d++) begin
            tests_run++;
            if (!cap_got || cap_seg[d] !== exp[d]) begin
                tests_failed++;
                $display("FAIL lz_0000_digit%0d: SEG=%h expected %h", d, cap_seg[d], exp[d]);
            end
        end
        tests_run++;
        if (!(cap_got && cap_sd_ok && cap_pulse_ok)) begin
            tests_failed++;
            $display("FAIL lz_shape: got=%b sd_ok=%b pulse_ok=%b expected 1 1 1",
                     cap_got, cap_sd_ok, cap_pulse_ok);
        end
    endtask

    task automatic test_decimal_point;
        logic [7:0] exp [4];
        load_word(16'h0000, 4'b0100, 1'b1);
        capture_frame(1'b0);
        exp = '{8'hC0, 8'hC0, 8'h40, 8'hFF};
        for (int d = 0; d < 4; d++) begin
            tests_run++;
            if (!cap_got || cap_seg[d] !== exp[d]) begin
                tests_failed++;
                $display("FAIL dp_digit%0d: SEG=%h expected %h", d, cap_seg[d], exp[d]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int n;
        int bad;
        int shows;
        repeat (2) @(negedge CLK);
        in_valid = 1'b1;
        in_data  = 16'h1111;
        in_dp    = 4'h0;
        in_lz    = 1'b0;
        @(posedge CLK);
        #1;
        in_data = 16'h2222;
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_ready_low: in_ready=%b expected 0", in_ready);
        end
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(posedge CLK);
            #1;
            n++;
        end
        tests_run++;
        if (in_ready !== 1'b1 || frame_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_ready_at_boundary: in_ready=%b fd=%b expected 1 1",
                     in_ready, frame_done);
        end
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        in_data  = 16'h0000;
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_second_taken: in_ready=%b expected 0", in_ready);
        end
        bad   = 0;
        shows = 0;
        n     = 0;
        @(negedge CLK);
        while (frame_done !== 1'b1 && n < 100) begin
            if (SD !== 4'hF) begin
                shows++;
                if (SEG !== 8'hF9) bad++;
            end
            @(negedge CLK);
            n++;
        end
        tests_run++;
        if (bad != 0 || shows != 16 || frame_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_first_frame: bad=%0d shows=%0d fd=%b expected 0 16 1",
                     bad, shows, frame_done);
        end
        capture_frame(1'b1);
        for (int d = 0; d < 4; d++) begin
            tests_run++;
            if (!cap_got || cap_seg[d] !== 8'hA4) begin
                tests_failed++;
                $display("FAIL b2b_second_digit%0d: SEG=%h expected A4", d, cap_seg[d]);
            end
        end
    endtask

    task automatic test_boundary_transfer;
        in_valid = 1'b1;
        in_data  = 16'h3333;
        in_dp    = 4'h0;
        in_lz    = 1'b0;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        in_data  = 16'h0000;
        tests_run++;
        if (frame_done !== 1'b1 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL bnd_held: fd=%b in_ready=%b expected 1 0", frame_done, in_ready);
        end
        capture_frame(1'b0);
        for (int d = 0; d < 4; d++) begin
            tests_run++;
            if (!cap_got || cap_seg[d] !== 8'hA4) begin
                tests_failed++;
                $display("FAIL bnd_old_digit%0d: SEG=%h expected A4", d, cap_seg[d]);
            end
        end
        capture_frame(1'b0);
        for (int d = 0; d < 4; d++) begin
            tests_run++;
            if (!cap_got || cap_seg[d] !== 8'hB0) begin
                tests_failed++;
                $display("FAIL bnd_new_digit%0d: SEG=%h expected B0", d, cap_seg[d]);
            end
        end
    endtask

    task automatic test_reset_mid;
        int n;
        n = 0;
        @(negedge CLK);
        while (frame_done !== 1'b1 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        in_valid = 1'b1;
        in_data  = 16'h4444;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        in_data  = 16'h0000;
        n = 0;
        @(negedge CLK);
        while (SD !== 4'b1011 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        tests_run++;
        if (SD !== 4'b1011 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_setup: SD=%b in_ready=%b expected 1011 0", SD, in_ready);
        end
        RST = 1'b0;
        #1;
        tests_run++;
        if (SD !== 4'hF || SEG !== 8'hFF || in_ready !== 1'b1 || frame_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_immediate: SD=%h SEG=%h rdy=%b fd=%b expected F FF 1 0",
                     SD, SEG, in_ready, frame_done);
        end
        @(posedge CLK);
        #1;
        RST = 1'b1;
        capture_frame(1'b0);
        capture_frame(1'b0);
        for (int d = 0; d < 4; d++) begin
            tests_run++;
            if (!cap_got || cap_seg[d] !== 8'hC0) begin
                tests_failed++;
                $display("FAIL rstmid_digit%0d: SEG=%h expected C0", d, cap_seg[d]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_leading_zero();
        test_decimal_point();
        test_back_to_back();
        test_boundary_transfer();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
